mem_port_master: RTL and testbench
==================================

# mem_port_master

Initiator side of the unified single-port synchronous memory. It accepts byte, half-word and word load/store requests from the multicycle datapath and drives the memory's `Adr`/`WE`/`WD` pins. It captures `RD`, then aligns and sign- or zero-extends load data. Sub-word stores are done as read-modify-write, because the memory only supports whole-word writes. Byte order is big-endian: byte offset 0 maps to bits 31:24.

## Interface
- `ADDR_W`, default 32: width of `req_addr` and `Adr`.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready` at a rising edge.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 treated as word.
- `req_unsigned` in 1: load zero-extends when 1, sign-extends when 0.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 32: store data, right-justified for sub-word sizes.
- `resp_valid` out 1: one-cycle completion pulse; no backpressure.
- `resp_rdata` out 32: extended load data; 0 for stores.
- `resp_err` out 1: misaligned-access flag, meaningful only with `MISALIGN_TRAP_EN`.
- `Adr` out ADDR_W: memory address, always word-aligned ([1:0] = 0).
- `WE` out 1: memory write enable.
- `WD` out 32: memory write data.
- `RD` in 32: memory read data, valid the cycle after the edge that sampled `Adr`.

## Operation
- FSM states: IDLE, READ, DATA, WRITE, RESP.
- `req_ready` = (state == IDLE) && !reset.
- On accept, the block registers the address, size, unsigned flag and write data.
- Load path: IDLE → READ → DATA → RESP → IDLE.
  - `Adr` is driven in READ.
  - At the DATA→RESP edge, the block selects the lane from `RD` and extends it into `resp_rdata`.
- Word store path: IDLE → WRITE → RESP → IDLE.
  - In WRITE: `WE` = 1 and `WD` = `req_wdata`.
- Sub-word store path: IDLE → READ → DATA → WRITE → RESP → IDLE.
  - At DATA, the selected lane of `RD` is replaced with the low byte or half of the stored data to form `WD`.
  - In WRITE, the merged word is written.
- Lane selection:
  - Byte: offset `addr[1:0]`; 0 → [31:24], 3 → [7:0].
  - Half: `addr[1]`; 0 → [31:16], 1 → [15:0].
- `WE` is high only in WRITE, for exactly one cycle per store.
- `resp_valid` is high only in RESP. `resp_rdata` and `resp_err` are held until the next RESP.
- Reset mid-operation: next state is IDLE and `WE` is 0 from the next cycle. A pending write is dropped and no response is issued.
- Reset values:
  - state IDLE.
  - `Adr`, `WD`, `resp_rdata` = 0.
  - `WE`, `resp_valid`, `resp_err`, `req_ready` = 0.

## Timing
- Edge E0 is the accepting edge.
- Load: READ follows E0; the memory samples `Adr` at E1; `RD` is valid in DATA; `resp_valid` is asserted in the cycle after E2.
- Word store: WRITE follows E0; the memory writes at E1; `resp_valid` is asserted in the cycle after E1.
- Sub-word store: the merge is registered at E2, the write happens at E3, and `resp_valid` is asserted in the cycle after E3.
- No new request is accepted until the cycle after RESP. A back-to-back request is accepted on the first edge at which the state is IDLE.
- All outputs are registered, or decoded from state registers only. There is no combinational path from `req_*` to the memory pins.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - A half access with `addr[0]` = 1, or a word access with `addr[1:0]` ≠ 0, goes IDLE → RESP directly.
  - No memory cycle occurs and `WE` is never asserted.
  - The response is `resp_err` = 1, `resp_rdata` = 0.
  - Aligned accesses respond with `resp_err` = 0.
- `MISALIGN_TRAP_EN` undefined:
  - Low address bits below the access size are ignored: half uses `addr[1]`, word ignores `addr[1:0]`.
  - `resp_err` is tied to 0.

## Test plan
- Memory [0x20] = 0x80A1B2C3.
  - Signed byte load at 0x20 → `resp_rdata` = 0xFFFFFF80, `resp_valid` asserted the 3rd cycle after accept.
  - Unsigned byte load at 0x20 → 0x00000080.
  - Signed half load at 0x22 → 0xFFFFB2C3.
- Memory [0x10] = 0x11223344.
  - Byte store of 0xAB to 0x12 → `WE` high for exactly 1 cycle; memory [0x10] becomes 0x1122AB44.
  - Half store of 0xBEEF to 0x12 → memory [0x10] becomes 0x1122BEEF.
- Word store of 0xDEADBEEF to 0x30, then word load from 0x30 → store completes 2 cycles after accept; load returns 0xDEADBEEF; `Adr` = 0x30 throughout.
- Word load at 0x21, with memory [0x20] = 0x80A1B2C3:
  - With `MISALIGN_TRAP_EN`: `resp_err` = 1 and `resp_rdata` = 0 in the cycle after accept; `WE` never high.
  - Without it: returns 0x80A1B2C3.
- Byte store to 0x12, with `reset` asserted during DATA → `WE` never asserted; memory [0x10] is unchanged; no `resp_valid`; `req_ready` = 1 the cycle after reset deasserts.

Source files
------------

// File: rtl/mem_port_master_if.sv
// Request/response and memory-pin bundle for mem_port_master.
// The master modport is the block's view; the slave modport is the datapath/memory side.
interface mem_port_master_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] Adr;
  logic              WE;
  logic [31:0]       WD;
  logic [31:0]       RD;

  modport master (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, RD,
    output req_ready, resp_valid, resp_rdata, resp_err, Adr, WE, WD
  );

  modport slave (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, RD,
    input  req_ready, resp_valid, resp_rdata, resp_err, Adr, WE, WD
  );
endinterface

// File: rtl/mem_port_master.sv
// Load/store initiator for a single-port word memory; big-endian lanes, RMW for sub-word stores.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned half/word accesses respond with resp_err).
module mem_port_lane (
  input  logic       sel,
  input  logic [7:0] old_b,
  input  logic [7:0] new_b,
  output logic [7:0] mrg_b
);
  assign mrg_b = sel ? new_b : old_b;
endmodule

module mem_port_master #(
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_master_if.master  bus
);
  localparam int NUM_LANES = 4;

  typedef enum logic [2:0] {IDLE, READ, DATA, WRITE, RESP} state_t;

  state_t            state, state_nxt;
  logic              accept, req_word, req_mis;
  logic [1:0]        off_q;
  logic [1:0]        size_q;
  logic              uns_q, we_q;
  logic [15:0]       wdata_q;
  logic [ADDR_W-1:0] adr_q;
  logic [31:0]       wd_q, rdata_q, ld_ext;
  logic [7:0]        ld_b;
  logic [15:0]       ld_h;

  logic [NUM_LANES-1:0][7:0] rd_lane, st_lane, mrg_lane;
  logic [NUM_LANES-1:0]      lane_sel;

  assign accept   = bus.req_valid && bus.req_ready;
  assign req_word = bus.req_size[1];

`ifdef MISALIGN_TRAP_EN
  logic err_q;
  assign req_mis = (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                   (bus.req_size[1] && bus.req_addr[1:0] != 2'b00);
  assign bus.resp_err = err_q;
`else
  assign req_mis      = 1'b0;
  assign bus.resp_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) begin
                 if (req_mis)                    state_nxt = RESP;
                 else if (bus.req_we && req_word) state_nxt = WRITE;
                 else                             state_nxt = READ;
               end
      READ:    state_nxt = DATA;
      DATA:    state_nxt = we_q ? WRITE : RESP;
      WRITE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lane 3 holds byte offset 0 (bits 31:24).
  assign rd_lane = bus.RD;
  always_comb begin
    st_lane  = {2{wdata_q}};
    lane_sel = 4'b1111;
    case (size_q)
      2'b00: begin
        st_lane  = {4{wdata_q[7:0]}};
        lane_sel = 4'b1000 >> off_q;
      end
      2'b01:   lane_sel = off_q[1] ? 4'b0011 : 4'b1100;
      default: lane_sel = 4'b1111;
    endcase
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    mem_port_lane u_lane (
      .sel   (lane_sel[g]),
      .old_b (rd_lane[g]),
      .new_b (st_lane[g]),
      .mrg_b (mrg_lane[g])
    );
  end

  always_comb begin
    ld_b   = rd_lane[2'd3 - off_q];
    ld_h   = off_q[1] ? bus.RD[15:0] : bus.RD[31:16];
    ld_ext = bus.RD;
    case (size_q)
      2'b00:   ld_ext = uns_q ? {24'b0, ld_b} : {{24{ld_b[7]}}, ld_b};
      2'b01:   ld_ext = uns_q ? {16'b0, ld_h} : {{16{ld_h[15]}}, ld_h};
      default: ld_ext = bus.RD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      off_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      adr_q   <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
`ifdef MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        off_q   <= bus.req_addr[1:0];
        size_q  <= bus.req_size;
        uns_q   <= bus.req_unsigned;
        we_q    <= bus.req_we;
        wdata_q <= bus.req_wdata[15:0];
        // A trapped access never touches the memory pins.
        if (!req_mis) adr_q <= {bus.req_addr[ADDR_W-1:2], 2'b00};
        if (!req_mis && bus.req_we && req_word) wd_q <= bus.req_wdata;
      end
      if (state == DATA && we_q)  wd_q    <= mrg_lane;
      if (state == DATA && !we_q) rdata_q <= ld_ext;
      if (state == WRITE)         rdata_q <= '0;
`ifdef MISALIGN_TRAP_EN
      if (state == DATA || state == WRITE) err_q <= 1'b0;
      if (accept && req_mis) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
`endif
    end
  end

  assign bus.req_ready  = (state == IDLE) && !reset;
  assign bus.WE         = (state == WRITE);
  assign bus.resp_valid = (state == RESP);
  assign bus.Adr        = adr_q;
  assign bus.WD         = wd_q;
  assign bus.resp_rdata = rdata_q;
endmodule

// File: tb/tb_mem_port_master.sv
// Directed bench for mem_port_master with a one-cycle-latency word memory model.
module tb_mem_port_master;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_master_if #(.ADDR_W(32)) bus();
  mem_port_master #(.ADDR_W(32)) dut (.clk(clk), .reset(reset), .bus(bus.master));

  logic [31:0] mem [0:63];
  logic        poke_en = 1'b0;
  logic [5:0]  poke_a  = '0;
  logic [31:0] poke_d  = '0;

  always @(posedge clk) begin
    if (poke_en)     mem[poke_a] <= poke_d;
    else if (bus.WE) mem[bus.Adr[7:2]] <= bus.WD;
    bus.RD <= mem[bus.Adr[7:2]];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_a = a[7:2]; poke_d = d;
    @(posedge clk); #1 poke_en = 1'b0;
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int cyc, output logic [31:0] rdata, output logic err,
                        output int wes, output logic adr_ok);
    int w;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
    bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wdata;
    w = 0;
    while (!bus.req_ready && w < 20) begin @(negedge clk); w++; end
    @(posedge clk); #1 bus.req_valid = 1'b0;
    cyc = -1; wes = 0; adr_ok = 1'b1; rdata = '0; err = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus.WE) wes++;
      if (bus.Adr !== {addr[31:2], 2'b00}) adr_ok = 1'b0;
      if (bus.resp_valid) begin cyc = n; rdata = bus.resp_rdata; err = bus.resp_err; break; end
    end
  endtask

  int cyc, wes;
  logic [31:0] rdata;
  logic err, adr_ok;

  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b expected 0", bus.req_ready); end
    n_checks++; if ({bus.WE, bus.resp_valid, bus.resp_err} !== 3'b000) begin n_fail++; $display("FAIL rst_ctl: got %b expected 000", {bus.WE, bus.resp_valid, bus.resp_err}); end
    n_checks++; if (bus.Adr !== 32'h0 || bus.WD !== 32'h0 || bus.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h/%h/%h expected 0/0/0", bus.Adr, bus.WD, bus.resp_rdata); end
    reset = 1'b0; #1;
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_rel: got %b expected 1", bus.req_ready); end
  endtask

  task automatic test_load();
    poke(8'h20, 32'h80A1B2C3);
    do_req(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, cyc, rdata, err, wes, adr_ok);
    n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL lb_lat: got %0d expected 3", cyc); end
    n_checks++; if (rdata !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_s: got %h expected ffffff80", rdata); end
    n_checks++; if (!adr_ok || wes !== 0) begin n_fail++; $display("FAIL lb_pins: got adr_ok=%b we=%0d expected 1/0", adr_ok, wes); end
    do_req(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, cyc, rdata, err, wes, adr_ok);
    n_checks++; if (rdata !== 32'h00000080) begin n_fail++; $display("FAIL lb_u: got %h expected 00000080", rdata); end
    do_req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, cyc, rdata, err, wes, adr_ok);
    n_checks++; if (rdata !== 32'hFFFFB2C3) begin n_fail++; $display("FAIL lh_s: got %h expected ffffb2c3", rdata); end
    do_req(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, cyc, rdata, err, wes, adr_ok);
    n_checks++; if (rdata !== 32'h000080A1) begin n_fail++; $display("FAIL lh_u: got %h expected 000080a1", rdata); end
    do_req(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, cyc, rdata, err, wes, adr_ok);
    n_checks++; if (rdata !== 32'hFFFFFFC3) begin n_fail++; $display("FAIL lb_off3: got %h expected ffffffc3", rdata); end
    do_req(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, cyc, rdata, err, wes, adr_ok);
    n_checks++; if (rdata !== 32'h000000A1) begin n_fail++; $display("FAIL lb_off1: got %h expected 000000a1", rdata); end
    do_req(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, cyc, rdata, err, wes, adr_ok);
    n_checks++; if (rdata !== 32'h80A1B2C3 || err !== 1'b0) begin n_fail++; $display("FAIL lw_size3: got %h err=%b expected 80a1b2c3 err=0", rdata, err); end
  endtask

  task automatic test_store_subword();
    poke(8'h10, 32'h11223344);
    do_req(1'b1, 2'b00, 1'b0, 32'h12, 32'h123456AB, cyc, rdata, err, wes, adr_ok);
    n_checks++; if (cyc !== 4) begin n_fail++; $display("FAIL sb_lat: got %0d expected 4", cyc); end
    n_checks++; if (wes !== 1) begin n_fail++; $display("FAIL sb_we: got %0d expected 1", wes); end
    n_checks++; if (mem[4] !== 32'h1122AB44) begin n_fail++; $display("FAIL sb_mem: got %h expected 1122ab44", mem[4]); end
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL sb_rdata: got %h expected 0", rdata); end
    do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h5555BEEF, cyc, rdata, err, wes, adr_ok);
    n_checks++; if (mem[4] !== 32'h1122BEEF || wes !== 1) begin n_fail++; $display("FAIL sh_mem: got %h we=%0d expected 1122beef we=1", mem[4], wes); end
    do_req(1'b1, 2'b00, 1'b0, 32'h10, 32'h000000CD, cyc, rdata, err, wes, adr_ok);
    n_checks++; if (mem[4] !== 32'hCD22BEEF) begin n_fail++; $display("FAIL sb_off0: got %h expected cd22beef", mem[4]); end
  endtask

  task automatic test_word();
    do_req(1'b1, 2'b10, 1'b0, 32'h30, 32'hDEADBEEF, cyc, rdata, err, wes, adr_ok);
    n_checks++; if (cyc !== 2) begin n_fail++; $display("FAIL sw_lat: got %0d expected 2", cyc); end
    n_checks++; if (wes !== 1 || !adr_ok) begin n_fail++; $display("FAIL sw_pins: got we=%0d adr_ok=%b expected 1/1", wes, adr_ok); end
    n_checks++; if (mem[12] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_mem: got %h expected deadbeef", mem[12]); end
    do_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, cyc, rdata, err, wes, adr_ok);
    n_checks++; if (rdata !== 32'hDEADBEEF || cyc !== 3 || !adr_ok) begin n_fail++; $display("FAIL lw: got %h lat=%0d adr_ok=%b expected deadbeef 3 1", rdata, cyc, adr_ok); end
  endtask

  task automatic test_back_to_back();
    do_req(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, cyc, rdata, err, wes, adr_ok);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b01;
    bus.req_unsigned = 1'b1; bus.req_addr = 32'h22;
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_busy: got %b expected 0", bus.req_ready); end
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got ready=%b rv=%b expected 1/0", bus.req_ready, bus.resp_valid); end
    n_checks++; if (bus.resp_rdata !== 32'h00000080) begin n_fail++; $display("FAIL b2b_hold: got %h expected 00000080", bus.resp_rdata); end
    @(posedge clk); #1 bus.req_valid = 1'b0;
    cyc = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus.resp_valid) begin cyc = n; rdata = bus.resp_rdata; break; end
    end
    n_checks++; if (cyc !== 3 || rdata !== 32'h0000B2C3) begin n_fail++; $display("FAIL b2b_resp: got lat=%0d %h expected 3 0000b2c3", cyc, rdata); end
  endtask

  task automatic test_misalign();
    do_req(1'b0, 2'b10, 1'b0, 32'h21, 32'h0, cyc, rdata, err, wes, adr_ok);
`ifdef MISALIGN_TRAP_EN
    n_checks++; if (cyc !== 1 || err !== 1'b1 || rdata !== 32'h0) begin n_fail++; $display("FAIL mis_trap: got lat=%0d err=%b %h expected 1 1 0", cyc, err, rdata); end
    n_checks++; if (wes !== 0) begin n_fail++; $display("FAIL mis_we: got %0d expected 0", wes); end
`else
    n_checks++; if (cyc !== 3 || err !== 1'b0 || rdata !== 32'h80A1B2C3) begin n_fail++; $display("FAIL mis_word: got lat=%0d err=%b %h expected 3 0 80a1b2c3", cyc, err, rdata); end
    n_checks++; if (wes !== 0 || !adr_ok) begin n_fail++; $display("FAIL mis_pins: got we=%0d adr_ok=%b expected 0/1", wes, adr_ok); end
`endif
  endtask

  task automatic test_reset_mid();
    int we_seen, rv_seen;
    poke(8'h10, 32'h11223344);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h12; bus.req_wdata = 32'h000000AB;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    n_checks++; if (bus.WE !== 1'b0) begin n_fail++; $display("FAIL rm_we_data: got %b expected 0", bus.WE); end
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 1'b0 || bus.WE !== 1'b0) begin n_fail++; $display("FAIL rm_in_rst: got ready=%b we=%b expected 0/0", bus.req_ready, bus.WE); end
    reset = 1'b0; #1;
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready: got %b expected 1", bus.req_ready); end
    we_seen = 0; rv_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.WE) we_seen++;
      if (bus.resp_valid) rv_seen++;
    end
    n_checks++; if (we_seen !== 0 || rv_seen !== 0) begin n_fail++; $display("FAIL rm_quiet: got we=%0d rv=%0d expected 0/0", we_seen, rv_seen); end
    n_checks++; if (mem[4] !== 32'h11223344) begin n_fail++; $display("FAIL rm_mem: got %h expected 11223344", mem[4]); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_subword();
    test_word();
    test_back_to_back();
    test_misalign();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
